// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked, parametrised ALU with multi-cycle shifts and multiply
//
// Carries the opcode map and flag semantics of the old 4-bit combinational ALU
// to any WIDTH. Shifts/rotates by a variable amount iterate one bit per cycle.
// MUL is an iterative shift-add multiply. Only one operation is in flight.
// Result and flags are registered and held until the consumer takes them.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   MUL_EN  1: MUL implemented, 0: MUL reports illegal
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid        operands/opcode present
//   in_ready        high only in IDLE
//   opcode[3:0]     operation select
//   a, b            operands; b[SHW-1:0] is the shift/rotate amount
//   out_valid       result/flags valid (DONE state)
//   out_ready       consumer takes the result
//   result          registered result
//   zero, negative, carry, overflow, illegal   registered flags
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH  = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    // Iteration counter must hold WIDTH (MUL) and any shift amount.
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INCA = 4'd2;
    localparam logic [3:0] OP_DECA = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   mcand;      // multiplicand held for the whole MUL
    logic [WIDTH-1:0]   work;       // shift/rotate working value
    logic [2*WIDTH-1:0] prod;       // {partial high, remaining multiplier}
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               is_shift;
    logic               mul_ok;
    logic               goes_busy;
    logic [SHW-1:0]     amt;
    logic               last;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   imm_res;
    logic               imm_c, imm_v, imm_ill;

    logic [WIDTH-1:0]   step_w;
    logic               step_c;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c, fin_v;

    // ------------------------------------------------------------------ decode
    assign accept    = in_valid && in_ready;
    assign amt       = b[SHW-1:0];
    assign is_shift  = (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA) ||
                       (opcode == OP_ROL) || (opcode == OP_ROR);
    assign mul_ok    = (opcode == OP_MUL) && (MUL_EN != 0);
    // Amount 0 shifts complete like single-cycle ops.
    assign goes_busy = (is_shift && (amt != '0)) || mul_ok;
    assign last      = (cnt == CW'(1));

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;

    // ------------------------------------------------- single-cycle datapath
    always_comb begin
        imm_res = '0;
        imm_c   = 1'b0;
        imm_v   = 1'b0;
        imm_ill = 1'b0;
        case (opcode)
            OP_ADD: begin
                imm_res = sum[WIDTH-1:0];
                imm_c   = sum[WIDTH];
                imm_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                imm_res = diff;
                imm_c   = (a >= b);                      // carry means no borrow
                imm_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INCA: begin
                imm_res = a + ONE;
                imm_c   = &a;
                imm_v   = (a == MAX_POS);
            end
            OP_DECA: begin
                imm_res = a - ONE;
                imm_c   = |a;
                imm_v   = (a == MIN_NEG);
            end
            OP_AND: imm_res = a & b;
            OP_OR:  imm_res = a | b;
            OP_XOR: imm_res = a ^ b;
            OP_NOT: imm_res = ~a;
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR:
                imm_res = a;                             // only used for amount 0
            OP_MUL: imm_ill = (MUL_EN == 0);
            default: imm_ill = 1'b1;
        endcase
    end

    // ------------------------------------------- one iteration of BUSY work
    // Shifting one bit per cycle for the full amount gives saturation for
    // amounts >= WIDTH and modulo behaviour for rotates without extra logic.
    always_comb begin
        step_w = work;
        step_c = 1'b0;
        case (op_q)
            OP_SLL: begin step_w = {work[WIDTH-2:0], 1'b0};         step_c = work[WIDTH-1]; end
            OP_SRL: begin step_w = {1'b0, work[WIDTH-1:1]};         step_c = work[0];       end
            OP_SRA: begin step_w = {work[WIDTH-1], work[WIDTH-1:1]}; step_c = work[0];      end
            OP_ROL: begin step_w = {work[WIDTH-2:0], work[WIDTH-1]}; step_c = work[WIDTH-1]; end
            OP_ROR: begin step_w = {work[0], work[WIDTH-1:1]};       step_c = work[0];      end
            default: ;
        endcase
    end

    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift the whole product right; the multiplier drains out of the low end.
    assign addend  = prod[0] ? mcand : '0;
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign prod_nx = {mul_sum, prod[WIDTH-1:1]};

    always_comb begin
        if (op_q == OP_MUL) begin
            fin_res = prod_nx[WIDTH-1:0];
            fin_c   = |prod_nx[2*WIDTH-1:WIDTH];
            fin_v   = fin_c;
        end else begin
            fin_res = step_w;
            fin_c   = step_c;
            fin_v   = 1'b0;
        end
    end

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = goes_busy ? BUSY : DONE;
            BUSY:    if (last)     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // --------------------------------------------------- datapath registers
    // Result and flags are written only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            mcand    <= '0;
            work     <= '0;
            prod     <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= opcode;
                    mcand <= a;
                    work  <= a;
                    prod  <= {{WIDTH{1'b0}}, b};
                    cnt   <= mul_ok ? CW'(WIDTH) : CW'(amt);
                    if (!goes_busy) begin
                        result   <= imm_res;
                        zero     <= (imm_res == '0);
                        negative <= imm_res[WIDTH-1];
                        carry    <= imm_c;
                        overflow <= imm_v;
                        illegal  <= imm_ill;
                    end
                end
                BUSY: begin
                    work <= step_w;
                    prod <= prod_nx;
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        result   <= fin_res;
                        zero     <= (fin_res == '0);
                        negative <= fin_res[WIDTH-1];
                        carry    <= fin_c;
                        overflow <= fin_v;
                        illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq at WIDTH 4, 8 and 5.
// Flag vectors are packed {zero, negative, carry, overflow, illegal}.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---- WIDTH=4
    logic       i4_v, o4_r, ir4, ov4, z4, n4, c4, v4, il4;
    logic [3:0] op4, a4, b4, r4;
    // ---- WIDTH=8
    logic       i8_v, o8_r, ir8, ov8, z8, n8, c8, v8, il8;
    logic [3:0] op8;
    logic [7:0] a8, b8, r8;
    // ---- WIDTH=5
    logic       i5_v, o5_r, ir5, ov5, z5, n5, c5, v5, il5;
    logic [3:0] op5;
    logic [4:0] a5, b5, r5;

    alu_seq #(.WIDTH(4), .MUL_EN(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(i4_v), .in_ready(ir4), .opcode(op4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(o4_r), .result(r4), .zero(z4), .negative(n4),
        .carry(c4), .overflow(v4), .illegal(il4));

    alu_seq #(.WIDTH(8), .MUL_EN(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(i8_v), .in_ready(ir8), .opcode(op8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(o8_r), .result(r8), .zero(z8), .negative(n8),
        .carry(c8), .overflow(v8), .illegal(il8));

    alu_seq #(.WIDTH(5), .MUL_EN(1)) dut5 (
        .clk(clk), .rst(rst), .in_valid(i5_v), .in_ready(ir5), .opcode(op5), .a(a5), .b(b5),
        .out_valid(ov5), .out_ready(o5_r), .result(r5), .zero(z5), .negative(n5),
        .carry(c5), .overflow(v5), .illegal(il5));

    // Issue one op, count edges from accept until out_valid, then hand off.
    task automatic run4(input logic [3:0] op, input logic [3:0] aa, input logic [3:0] bb,
                        output int lat, output logic [7:0] r, output logic [4:0] f);
        @(negedge clk); i4_v = 1'b1; op4 = op; a4 = aa; b4 = bb;
        @(posedge clk); #1; i4_v = 1'b0; lat = 1;
        while (!ov4 && lat < 40) begin @(posedge clk); #1; lat++; end
        r = {4'b0, r4}; f = {z4, n4, c4, v4, il4};
        @(negedge clk); o4_r = 1'b1; @(posedge clk); #1; o4_r = 1'b0;
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                        output int lat, output logic [7:0] r, output logic [4:0] f);
        @(negedge clk); i8_v = 1'b1; op8 = op; a8 = aa; b8 = bb;
        @(posedge clk); #1; i8_v = 1'b0; lat = 1;
        while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
        r = r8; f = {z8, n8, c8, v8, il8};
        @(negedge clk); o8_r = 1'b1; @(posedge clk); #1; o8_r = 1'b0;
    endtask

    task automatic run5(input logic [3:0] op, input logic [4:0] aa, input logic [4:0] bb,
                        output int lat, output logic [7:0] r, output logic [4:0] f);
        @(negedge clk); i5_v = 1'b1; op5 = op; a5 = aa; b5 = bb;
        @(posedge clk); #1; i5_v = 1'b0; lat = 1;
        while (!ov5 && lat < 40) begin @(posedge clk); #1; lat++; end
        r = {3'b0, r5}; f = {z5, n5, c5, v5, il5};
        @(negedge clk); o5_r = 1'b1; @(posedge clk); #1; o5_r = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i4_v = 0; o4_r = 0; op4 = 0; a4 = 0; b4 = 0;
        i8_v = 0; o8_r = 0; op8 = 0; a8 = 0; b8 = 0;
        i5_v = 0; o5_r = 0; op5 = 0; a5 = 0; b5 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({ov4, r4, z4, n4, c4, v4, il4, ir4} !== {1'b0, 4'h0, 5'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_w4: ov=%b r=%h f=%b rdy=%b want ov=0 r=0 f=00000 rdy=1",
                     ov4, r4, {z4, n4, c4, v4, il4}, ir4);
        end
        tests++;
        if ({ov8, r8, z8, n8, c8, v8, il8, ir8} !== {1'b0, 8'h00, 5'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_w8: ov=%b r=%h f=%b rdy=%b want ov=0 r=00 f=00000 rdy=1",
                     ov8, r8, {z8, n8, c8, v8, il8}, ir8);
        end
    endtask

    // {op, a, b, result, flags, latency}
    task automatic test_alu4();
        int t [15][6] = '{
            '{0,  7, 1,  8, 'b01010, 1},
            '{1,  3, 5, 14, 'b01000, 1},
            '{1,  5, 5,  0, 'b10100, 1},
            '{1,  8, 1,  7, 'b00110, 1},
            '{0,  9, 8,  1, 'b00110, 1},
            '{2, 15, 0,  0, 'b10100, 1},
            '{2,  7, 0,  8, 'b01010, 1},
            '{3,  8, 0,  7, 'b00110, 1},
            '{3,  0, 0, 15, 'b01000, 1},
            '{4, 12,10,  8, 'b01000, 1},
            '{5,  5, 2,  7, 'b00000, 1},
            '{6, 15,15,  0, 'b10000, 1},
            '{7,  5, 0, 10, 'b01000, 1},
            '{14, 3, 4,  0, 'b10001, 1},
            '{15, 9, 9,  0, 'b10001, 1}};
        int lat; logic [7:0] r; logic [4:0] f;
        for (int i = 0; i < 15; i++) begin
            run4(4'(t[i][0]), 4'(t[i][1]), 4'(t[i][2]), lat, r, f);
            tests++;
            if (r !== 8'(t[i][3]) || f !== 5'(t[i][4]) || lat != t[i][5]) begin
                fails++;
                $display("FAIL alu4[%0d] op=%0d: r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                         i, t[i][0], r, f, lat, 8'(t[i][3]), 5'(t[i][4]), t[i][5]);
            end
        end
    endtask

    task automatic test_shift_mul4();
        int t [6][6] = '{
            '{8,  3, 4,  3, 'b00000, 1},
            '{8,  9, 1,  2, 'b00100, 2},
            '{12, 1, 3,  2, 'b00000, 4},
            '{10, 8, 2, 14, 'b01000, 3},
            '{13, 3, 5, 15, 'b01000, 5},
            '{13,15,15,  1, 'b00110, 5}};
        int lat; logic [7:0] r; logic [4:0] f;
        for (int i = 0; i < 6; i++) begin
            run4(4'(t[i][0]), 4'(t[i][1]), 4'(t[i][2]), lat, r, f);
            tests++;
            if (r !== 8'(t[i][3]) || f !== 5'(t[i][4]) || lat != t[i][5]) begin
                fails++;
                $display("FAIL shmul4[%0d] op=%0d: r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                         i, t[i][0], r, f, lat, 8'(t[i][3]), 5'(t[i][4]), t[i][5]);
            end
        end
    endtask

    task automatic test_w8();
        int t [8][6] = '{
            '{10, 'h90, 3,    'hF2, 'b01000, 4},
            '{11, 'h81, 1,    'h03, 'b00100, 2},
            '{9,  'hC0, 7,    'h01, 'b00100, 8},
            '{12, 'h01, 8,    'h01, 'b00000, 1},
            '{13, 20,   13,   'h04, 'b00110, 9},
            '{13, 3,    5,    'h0F, 'b00000, 9},
            '{13, 'hFF, 'hFF, 'h01, 'b00110, 9},
            '{13, 0,    'hC8, 'h00, 'b10000, 9}};
        int lat; logic [7:0] r; logic [4:0] f;
        for (int i = 0; i < 8; i++) begin
            run8(4'(t[i][0]), 8'(t[i][1]), 8'(t[i][2]), lat, r, f);
            tests++;
            if (r !== 8'(t[i][3]) || f !== 5'(t[i][4]) || lat != t[i][5]) begin
                fails++;
                $display("FAIL w8[%0d] op=%0d: r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                         i, t[i][0], r, f, lat, 8'(t[i][3]), 5'(t[i][4]), t[i][5]);
            end
        end
    endtask

    // Non-power-of-2 width: amounts beyond WIDTH saturate / wrap.
    task automatic test_sat5();
        int t [4][6] = '{
            '{8,  'h1F, 6, 'h00, 'b10000, 7},
            '{10, 'h10, 7, 'h1F, 'b01100, 8},
            '{12, 'h01, 6, 'h10, 'b01100, 7},
            '{9,  'h1F, 7, 'h00, 'b10000, 8}};
        int lat; logic [7:0] r; logic [4:0] f;
        for (int i = 0; i < 4; i++) begin
            run5(4'(t[i][0]), 5'(t[i][1]), 5'(t[i][2]), lat, r, f);
            tests++;
            if (r !== 8'(t[i][3]) || f !== 5'(t[i][4]) || lat != t[i][5]) begin
                fails++;
                $display("FAIL sat5[%0d] op=%0d: r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                         i, t[i][0], r, f, lat, 8'(t[i][3]), 5'(t[i][4]), t[i][5]);
            end
        end
    endtask

    task automatic test_hold8();
        @(negedge clk); i8_v = 1'b1; op8 = 4'd0; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #1;
        op8 = 4'd1; a8 = 8'h00; b8 = 8'h01;   // keep in_valid up: must be ignored
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({ov8, ir8, r8, z8, n8, c8, v8, il8} !== {1'b1, 1'b0, 8'h80, 5'b01010}) begin
                fails++;
                $display("FAIL hold8[%0d]: ov=%b rdy=%b r=%h f=%b want ov=1 rdy=0 r=80 f=01010",
                         k, ov8, ir8, r8, {z8, n8, c8, v8, il8});
            end
            @(posedge clk); #1;
        end
        @(negedge clk); i8_v = 1'b0; o8_r = 1'b1;
        @(posedge clk); #1; o8_r = 1'b0;
        tests++;
        if ({ov8, ir8} !== 2'b01) begin
            fails++;
            $display("FAIL hold8_release: ov=%b rdy=%b want ov=0 rdy=1", ov8, ir8);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] vseen, rseen;
        @(negedge clk); i4_v = 1'b1; op4 = 4'd0; a4 = 4'd1; b4 = 4'd2; o4_r = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            vseen[k] = ov4; rseen[k] = ir4;
        end
        @(negedge clk); i4_v = 1'b0; o4_r = 1'b0;
        tests++;
        if ({vseen, rseen} !== {6'b010101, 6'b101010}) begin
            fails++;
            $display("FAIL back_to_back: valid=%b ready=%b want valid=010101 ready=101010",
                     vseen, rseen);
        end
        tests++;
        if (r4 !== 4'd3) begin
            fails++;
            $display("FAIL back_to_back_result: r=%h want 3", r4);
        end
    endtask

    task automatic test_reset_mid_mul();
        int vcount = 0;
        int lat; logic [7:0] r; logic [4:0] f;
        @(negedge clk); i8_v = 1'b1; op8 = 4'd13; a8 = 8'd20; b8 = 8'd13;
        @(posedge clk); #1; i8_v = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({ov8, r8, z8, n8, c8, v8, il8, ir8} !== {1'b0, 8'h00, 5'b0, 1'b1}) begin
            fails++;
            $display("FAIL rst_mid_mul: ov=%b r=%h f=%b rdy=%b want ov=0 r=00 f=00000 rdy=1",
                     ov8, r8, {z8, n8, c8, v8, il8}, ir8);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ov8) vcount++;
        end
        tests++;
        if (vcount != 0) begin
            fails++;
            $display("FAIL rst_discard: out_valid seen %0d cycles want 0", vcount);
        end
        run8(4'd15, 8'h12, 8'h34, lat, r, f);
        tests++;
        if (r !== 8'h00 || f !== 5'b10001 || lat != 1) begin
            fails++;
            $display("FAIL illegal8: r=%h f=%b lat=%0d want r=00 f=10001 lat=1", r, f, lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu4();
        test_shift_mul4();
        test_w8();
        test_sat5();
        test_hold8();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
